adc_scan_ctrl: RTL and testbench
================================

ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 SHALL have parameter TO_W, default 24, watchdog counter width in bits.
REQ-002 SHALL have ports clk input 1 (single clock, all logic on rising edge), reset_n input 1 (synchronous, active-low).
REQ-003 SHALL have host slave ports avs_ctrl_address input 2, avs_ctrl_write input 1, avs_ctrl_writedata input 16, avs_ctrl_read input 1, avs_ctrl_readdata output 16 (combinational, zero wait).
REQ-004 SHALL have readout master ports avm_address output 2, avm_write output 1, avm_writedata output 16, avm_read output 1, avm_readdata input 16 (valid in same cycle as avm_read).
REQ-005 SHALL have outputs busy 1 (scan in progress), done 1 (one-cycle pulse at scan end), irq 1 (level, set at scan end, cleared by host status read).

Function
REQ-006 Host registers SHALL be: addr0 W bit0 go, bit1 abort; R {12'h0, timeout_err, aborted, irq, busy}; addr1 {ssel[15:14], step[11:8], sdel0[5:0]}; addr2 count[7:0]; addr3 W len, R last_size.
REQ-007 FSM states SHALL be IDLE, CFG_LEN, CFG_DEL, ARM, WAIT_TRIG, WAIT_DONE, RD_SIZE, NEXT; each master access SHALL occupy exactly one cycle.
REQ-008 IDLE + go (count!=0) SHALL load cur_del=sdel0, remaining=count, clear aborted/timeout_err, set busy, enter CFG_LEN next cycle; go with count==0 SHALL pulse done without any master access.
REQ-009 CFG_LEN SHALL write avm addr3 = len; CFG_DEL SHALL write addr1 = {ssel, 8'h00, cur_del}; ARM SHALL write addr0 = 16'h0002 (single=1, cont=0).
REQ-010 WAIT_TRIG SHALL read addr0 every cycle, advancing when readdata[1]==0 (single consumed); WAIT_DONE SHALL read addr0 every cycle, advancing when readdata[2]==0.
REQ-011 RD_SIZE SHALL read addr3 and latch last_size; NEXT SHALL set cur_del=(cur_del+step) mod 64, decrement remaining, go to CFG_DEL if remaining!=0 after decrement, else IDLE with done pulse and irq set.
REQ-012 go while busy SHALL be ignored; go and abort in same write SHALL act as abort only.
REQ-013 abort while busy SHALL, next cycle, write addr0 = 16'h0000 (disarm), then enter IDLE, set aborted and irq, clear busy, no done pulse; abort in IDLE SHALL have no effect.
REQ-014 Only one of avm_write/avm_read SHALL be high per cycle; both low in IDLE.
REQ-015 Host reads of addr0 SHALL clear irq in the following cycle unless a new set coincides (set wins).

Reset
REQ-016 reset_n low SHALL force IDLE, busy=0, done=0, irq=0, avm_write=0, avm_read=0, avm_address=0, avm_writedata=0, all registers/flags/counters zero, including mid-scan.
REQ-017 Reset mid-scan SHALL NOT issue a disarm write; readout block is reset by its own reset.

Configuration
REQ-018 Macro ADC_SCAN_WATCHDOG_EN SHALL compile in a TO_W-bit watchdog counting cycles in WAIT_TRIG/WAIT_DONE, cleared on state entry.
REQ-019 With macro: counter reaching all-ones SHALL behave as abort (REQ-013) and additionally set timeout_err.
REQ-020 Without macro: no watchdog logic, timeout_err reads 0, wait states unbounded.

Structure
REQ-021 Package adc_scan_pkg SHALL hold the state enum, host/readout register address constants, and ARM/DISARM data constants.
REQ-022 Watchdog SHALL be sub-module adc_scan_watchdog (clk, reset_n, clear, enable, expired), instantiated only under ADC_SCAN_WATCHDOG_EN.

Verification
REQ-023 sdel0=5, step=3, count=3, len=100, model readout -> addr1 writes carry sdel 5, 8, 11; three addr0 arm writes; one done pulse; busy low after.
REQ-024 sdel0=62, step=4, count=2 -> second CFG_DEL writes sdel=2 (wrap mod 64).
REQ-025 count=0, go -> done pulse next cycle, zero avm_write/avm_read cycles.
REQ-026 Abort during WAIT_DONE of scan 2 of 4 -> one addr0 write 0x0000, aborted=1, irq=1, no done, status read then clears irq.
REQ-027 With ADC_SCAN_WATCHDOG_EN, TO_W=8, trigger never fires -> after 255 WAIT_TRIG cycles disarm write, timeout_err=1, aborted=1.
REQ-028 reset_n low for one cycle in WAIT_TRIG -> next cycle all outputs zero, state IDLE, subsequent go restarts from CFG_LEN.

Source files
------------

// File: rtl/adc_scan_pkg.sv
// adc_scan_pkg: shared FSM state type, host/readout register map and
// readout control data words for the ADC delay-scan controller.
package adc_scan_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CFG_LEN,
    ST_CFG_DEL,
    ST_ARM,
    ST_WAIT_TRIG,
    ST_WAIT_DONE,
    ST_RD_SIZE,
    ST_NEXT,
    ST_DISARM
  } scan_state_e;

  // Host-side register addresses
  localparam logic [1:0] HOST_CTRL  = 2'd0;
  localparam logic [1:0] HOST_SCAN  = 2'd1;
  localparam logic [1:0] HOST_COUNT = 2'd2;
  localparam logic [1:0] HOST_LEN   = 2'd3;

  // Readout-block register addresses
  localparam logic [1:0] RO_CTRL  = 2'd0;
  localparam logic [1:0] RO_DELAY = 2'd1;
  localparam logic [1:0] RO_LEN   = 2'd3;

  // Readout control words: arm = single-shot, not continuous; disarm = all clear
  localparam logic [15:0] RO_ARM_DATA    = 16'h0002;
  localparam logic [15:0] RO_DISARM_DATA = 16'h0000;

  // Readout status bit positions
  localparam int unsigned RO_SINGLE_BIT = 1;
  localparam int unsigned RO_BUSY_BIT   = 2;

endpackage

// File: rtl/adc_scan_watchdog.sv
// adc_scan_watchdog: free-running cycle counter for the readout wait states.
// Only instantiated when ADC_SCAN_WATCHDOG_EN is defined.
module adc_scan_watchdog #(
  parameter int unsigned TO_W = 24
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] r_cnt;

  // Count enabled cycles; clear takes priority so each wait state starts at zero
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  assign expired = &r_cnt;

endmodule

// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: host-programmed delay scan over a readout block.
// Optional build macro: ADC_SCAN_WATCHDOG_EN (bounds the readout wait states).
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int unsigned TO_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  // host slave
  input  logic [1:0]  avs_ctrl_address,
  input  logic        avs_ctrl_write,
  input  logic [15:0] avs_ctrl_writedata,
  input  logic        avs_ctrl_read,
  output logic [15:0] avs_ctrl_readdata,
  // readout master
  output logic [1:0]  avm_address,
  output logic        avm_write,
  output logic [15:0] avm_writedata,
  output logic        avm_read,
  input  logic [15:0] avm_readdata,
  // status
  output logic        busy,
  output logic        done,
  output logic        irq
);

  scan_state_e r_state, w_state_nxt;

  logic [1:0]  r_ssel;
  logic [3:0]  r_step;
  logic [5:0]  r_sdel0;
  logic [7:0]  r_count;
  logic [15:0] r_len;
  logic [15:0] r_last_size;
  logic [5:0]  r_cur_del;
  logic [7:0]  r_remaining;
  logic        r_aborted;
  logic        r_timeout_err;
  logic        r_irq;
  logic        r_done;

  logic w_ctrl_wr;
  logic w_go;
  logic w_abort;
  logic w_timeout;
  logic w_stop;
  logic w_go_start;
  logic w_go_zero;
  logic w_in_wait;

  assign w_ctrl_wr  = avs_ctrl_write && (avs_ctrl_address == HOST_CTRL);
  // go together with abort acts as abort only
  assign w_go       = w_ctrl_wr && avs_ctrl_writedata[0] && !avs_ctrl_writedata[1];
  assign w_abort    = w_ctrl_wr && avs_ctrl_writedata[1];
  assign w_in_wait  = (r_state == ST_WAIT_TRIG) || (r_state == ST_WAIT_DONE);
  assign w_stop     = (w_abort || w_timeout) && (r_state != ST_IDLE) && (r_state != ST_DISARM);
  assign w_go_start = (r_state == ST_IDLE) && w_go && (r_count != 8'd0);
  assign w_go_zero  = (r_state == ST_IDLE) && w_go && (r_count == 8'd0);

`ifdef ADC_SCAN_WATCHDOG_EN
  logic w_wd_clear;
  logic w_wd_expired;

  assign w_wd_clear = (w_state_nxt != r_state);
  assign w_timeout  = w_in_wait && w_wd_expired;

  adc_scan_watchdog #(
    .TO_W (TO_W)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (w_wd_clear),
    .enable  (w_in_wait),
    .expired (w_wd_expired)
  );
`else
  // No watchdog: wait states are unbounded; TO_W kept for a uniform parameter list
  assign w_timeout = 1'b0 & (TO_W != 0) & w_in_wait;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and readout master access (one access per state cycle)
  always_comb begin
    w_state_nxt   = r_state;
    avm_write     = 1'b0;
    avm_read      = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_go_start) w_state_nxt = ST_CFG_LEN;
      end
      ST_CFG_LEN: begin
        avm_write     = 1'b1;
        avm_address   = RO_LEN;
        avm_writedata = r_len;
        w_state_nxt   = ST_CFG_DEL;
      end
      ST_CFG_DEL: begin
        avm_write     = 1'b1;
        avm_address   = RO_DELAY;
        avm_writedata = {r_ssel, 8'h00, r_cur_del};
        w_state_nxt   = ST_ARM;
      end
      ST_ARM: begin
        avm_write     = 1'b1;
        avm_address   = RO_CTRL;
        avm_writedata = RO_ARM_DATA;
        w_state_nxt   = ST_WAIT_TRIG;
      end
      ST_WAIT_TRIG: begin
        avm_read    = 1'b1;
        avm_address = RO_CTRL;
        if (!avm_readdata[RO_SINGLE_BIT]) w_state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        avm_read    = 1'b1;
        avm_address = RO_CTRL;
        if (!avm_readdata[RO_BUSY_BIT]) w_state_nxt = ST_RD_SIZE;
      end
      ST_RD_SIZE: begin
        avm_read    = 1'b1;
        avm_address = RO_LEN;
        w_state_nxt = ST_NEXT;
      end
      ST_NEXT: begin
        // remaining is always >= 1 here; == 1 means it reaches zero now
        w_state_nxt = (r_remaining == 8'd1) ? ST_IDLE : ST_CFG_DEL;
      end
      ST_DISARM: begin
        avm_write     = 1'b1;
        avm_address   = RO_CTRL;
        avm_writedata = RO_DISARM_DATA;
        w_state_nxt   = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_stop) w_state_nxt = ST_DISARM;
  end

  // Host registers, scan progress, and status flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ssel        <= '0;
      r_step        <= '0;
      r_sdel0       <= '0;
      r_count       <= '0;
      r_len         <= '0;
      r_last_size   <= '0;
      r_cur_del     <= '0;
      r_remaining   <= '0;
      r_aborted     <= 1'b0;
      r_timeout_err <= 1'b0;
      r_irq         <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (avs_ctrl_write) begin
        case (avs_ctrl_address)
          HOST_SCAN: begin
            r_ssel  <= avs_ctrl_writedata[15:14];
            r_step  <= avs_ctrl_writedata[11:8];
            r_sdel0 <= avs_ctrl_writedata[5:0];
          end
          HOST_COUNT: r_count <= avs_ctrl_writedata[7:0];
          HOST_LEN:   r_len   <= avs_ctrl_writedata;
          default: ;
        endcase
      end
      // Status read clears irq; any set below in the same cycle wins
      if (avs_ctrl_read && (avs_ctrl_address == HOST_CTRL)) r_irq <= 1'b0;
      if (w_go_start) begin
        r_cur_del     <= r_sdel0;
        r_remaining   <= r_count;
        r_aborted     <= 1'b0;
        r_timeout_err <= 1'b0;
      end
      if (w_go_zero) r_done <= 1'b1;
      if (r_state == ST_RD_SIZE) r_last_size <= avm_readdata;
      if ((r_state == ST_NEXT) && !w_stop) begin
        r_cur_del   <= r_cur_del + {2'b00, r_step};
        r_remaining <= r_remaining - 8'd1;
        if (r_remaining == 8'd1) begin
          r_done <= 1'b1;
          r_irq  <= 1'b1;
        end
      end
      if (w_stop && w_timeout) r_timeout_err <= 1'b1;
      if (r_state == ST_DISARM) begin
        r_aborted <= 1'b1;
        r_irq     <= 1'b1;
      end
    end
  end

  // Zero-wait host read mux
  always_comb begin
    case (avs_ctrl_address)
      HOST_CTRL:  avs_ctrl_readdata = {12'h000, r_timeout_err, r_aborted, r_irq, busy};
      HOST_SCAN:  avs_ctrl_readdata = {r_ssel, 2'b00, r_step, 2'b00, r_sdel0};
      HOST_COUNT: avs_ctrl_readdata = {8'h00, r_count};
      default:    avs_ctrl_readdata = r_last_size;
    endcase
  end

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign irq  = r_irq;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// tb_adc_scan_ctrl: scoreboard bench for adc_scan_ctrl with a small readout model.
module tb_adc_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  avs_ctrl_address;
  logic        avs_ctrl_write;
  logic [15:0] avs_ctrl_writedata;
  logic        avs_ctrl_read;
  logic [15:0] avs_ctrl_readdata;
  logic [1:0]  avm_address;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic        avm_read;
  logic [15:0] avm_readdata;
  logic        busy;
  logic        done;
  logic        irq;

  int errors = 0;
  int checks = 0;
  int access_cnt = 0;
  int done_cnt = 0;
  int arm_cnt = 0;
  logic prev_done = 1'b0;

  logic [17:0] exp_q[$];

  // readout model
  logic        m_single, m_busy;
  int unsigned m_tcnt, m_bcnt;
  logic        trig_en;
  logic [15:0] size_val;

  int base_done, base_acc, base_arm, n;
  logic [15:0] rd;

  always #5 clk = ~clk;

  adc_scan_ctrl #(.TO_W(8)) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .avs_ctrl_address   (avs_ctrl_address),
    .avs_ctrl_write     (avs_ctrl_write),
    .avs_ctrl_writedata (avs_ctrl_writedata),
    .avs_ctrl_read      (avs_ctrl_read),
    .avs_ctrl_readdata  (avs_ctrl_readdata),
    .avm_address        (avm_address),
    .avm_write          (avm_write),
    .avm_writedata      (avm_writedata),
    .avm_read           (avm_read),
    .avm_readdata       (avm_readdata),
    .busy               (busy),
    .done               (done),
    .irq                (irq)
  );

  // Readout block: arm sets single; trigger clears it after a delay and runs busy
  always @(posedge clk) begin
    if (!reset_n) begin
      m_single <= 1'b0;
      m_busy   <= 1'b0;
      m_tcnt   <= 0;
      m_bcnt   <= 0;
    end else if (avm_write && avm_address == 2'd0) begin
      m_single <= avm_writedata[1];
      m_busy   <= 1'b0;
      m_tcnt   <= 2;
    end else begin
      if (m_single && trig_en) begin
        if (m_tcnt == 0) begin
          m_single <= 1'b0;
          m_busy   <= 1'b1;
          m_bcnt   <= 6;
        end else begin
          m_tcnt <= m_tcnt - 1;
        end
      end
      if (m_busy) begin
        if (m_bcnt == 0) m_busy <= 1'b0;
        else m_bcnt <= m_bcnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (avm_write && avm_address == 2'd0 && avm_writedata[1]) arm_cnt <= arm_cnt + 1;
  end

  always_comb begin
    if (avm_address == 2'd0) avm_readdata = {13'h0, m_busy, m_single, 1'b0};
    else if (avm_address == 2'd3) avm_readdata = size_val;
    else avm_readdata = 16'h0;
  end

  // Monitor: compares every master write against the scoreboard queue
  always @(negedge clk) begin
    if (reset_n) begin
      if (avm_write || avm_read) access_cnt++;
      if (avm_write && avm_read) begin
        checks++;
        errors++;
        $display("FAIL bus_excl: write and read both high at %0t", $time);
      end
      if (avm_write) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL avm_write_unexp: got addr=%0d data=0x%04h, expected no write", avm_address, avm_writedata);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          if ({avm_address, avm_writedata} !== e) begin
            errors++;
            $display("FAIL avm_write: got addr=%0d data=0x%04h, expected addr=%0d data=0x%04h",
                     avm_address, avm_writedata, e[17:16], e[15:0]);
          end
        end
      end
      if (done) begin
        done_cnt++;
        if (prev_done) begin
          checks++;
          errors++;
          $display("FAIL done_width: got 2-cycle pulse, expected 1 cycle");
        end
      end
      prev_done <= done;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic host_write(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    avs_ctrl_address   = a;
    avs_ctrl_writedata = d;
    avs_ctrl_write     = 1'b1;
    @(negedge clk);
    avs_ctrl_write     = 1'b0;
  endtask

  task automatic host_read(input logic [1:0] a, output logic [15:0] d);
    @(negedge clk);
    avs_ctrl_address = a;
    avs_ctrl_read    = 1'b1;
    #1 d = avs_ctrl_readdata;
    @(negedge clk);
    avs_ctrl_read    = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("idle_wait", {31'd0, busy}, 32'd0);
  endtask

  task automatic push(input logic [1:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    avs_ctrl_address = '0;
    avs_ctrl_write = 1'b0;
    avs_ctrl_writedata = '0;
    avs_ctrl_read = 1'b0;
    trig_en = 1'b1;
    size_val = 16'h0123;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_avm", {avm_write, avm_read, avm_address, avm_writedata}, 32'd0);
    host_read(2'd0, rd);
    check("rst_status", {16'd0, rd}, 32'd0);

    // scan: sdel0=5 step=3 count=3 len=100 ssel=1
    host_write(2'd1, 16'h4305);
    host_write(2'd2, 16'd3);
    host_write(2'd3, 16'd100);
    push(2'd3, 16'd100);
    push(2'd1, 16'h4005); push(2'd0, 16'h0002);
    push(2'd1, 16'h4008); push(2'd0, 16'h0002);
    push(2'd1, 16'h400B); push(2'd0, 16'h0002);
    base_done = done_cnt;
    host_write(2'd0, 16'h0001);
    host_read(2'd0, rd);
    check("a_status_busy", {16'd0, rd}, 32'h0001);
    wait_idle(2000);
    repeat (2) @(negedge clk);
    check("a_done_cnt", done_cnt - base_done, 32'd1);
    check("a_queue_empty", exp_q.size(), 32'd0);
    host_read(2'd3, rd);
    check("a_last_size", {16'd0, rd}, 32'h0123);
    host_read(2'd0, rd);
    check("a_status_irq", {16'd0, rd}, 32'h0002);
    host_read(2'd0, rd);
    check("a_irq_cleared", {16'd0, rd}, 32'h0000);

    // scan: sdel0=62 step=4 count=2 ssel=2 -> delay wraps to 2
    size_val = 16'h0BEE;
    host_write(2'd1, 16'h843E);
    host_write(2'd2, 16'd2);
    push(2'd3, 16'd100);
    push(2'd1, 16'h803E); push(2'd0, 16'h0002);
    push(2'd1, 16'h8002); push(2'd0, 16'h0002);
    base_done = done_cnt;
    host_write(2'd0, 16'h0001);
    wait_idle(2000);
    repeat (2) @(negedge clk);
    check("b_done_cnt", done_cnt - base_done, 32'd1);
    check("b_queue_empty", exp_q.size(), 32'd0);
    host_read(2'd3, rd);
    check("b_last_size", {16'd0, rd}, 32'h0BEE);
    host_read(2'd0, rd);
    check("b_status_irq", {16'd0, rd}, 32'h0002);

    // count=0: done next cycle, no master traffic
    host_write(2'd2, 16'd0);
    base_acc = access_cnt;
    base_done = done_cnt;
    host_write(2'd0, 16'h0001);
    check("c_done_pulse", {31'd0, done}, 32'd1);
    check("c_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("c_no_access", access_cnt - base_acc, 32'd0);
    check("c_done_cnt", done_cnt - base_done, 32'd1);

    // abort during WAIT_DONE of scan 2 of 4
    host_write(2'd1, 16'h0100);
    host_write(2'd2, 16'd4);
    push(2'd3, 16'd100);
    push(2'd1, 16'h0000); push(2'd0, 16'h0002);
    push(2'd1, 16'h0001); push(2'd0, 16'h0002);
    push(2'd0, 16'h0000);
    base_done = done_cnt;
    base_arm = arm_cnt;
    host_write(2'd0, 16'h0001);
    n = 0;
    while (!(arm_cnt == base_arm + 2 && m_busy && avm_read) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("d_reach_wait_done", {31'd0, (n < 2000)}, 32'd1);
    host_write(2'd0, 16'h0002);
    wait_idle(100);
    repeat (2) @(negedge clk);
    check("d_no_done", done_cnt - base_done, 32'd0);
    check("d_queue_empty", exp_q.size(), 32'd0);
    host_read(2'd0, rd);
    check("d_status_abort", {16'd0, rd}, 32'h0006);
    host_read(2'd0, rd);
    check("d_irq_cleared", {16'd0, rd}, 32'h0004);

    // abort in IDLE, and go+abort together: no effect
    base_acc = access_cnt;
    host_write(2'd0, 16'h0002);
    host_write(2'd0, 16'h0003);
    repeat (3) @(negedge clk);
    check("d_idle_busy", {31'd0, busy}, 32'd0);
    check("d_idle_no_access", access_cnt - base_acc, 32'd0);
    host_read(2'd0, rd);
    check("d_idle_status", {16'd0, rd}, 32'h0004);

`ifdef ADC_SCAN_WATCHDOG_EN
    // watchdog: trigger never fires
    trig_en = 1'b0;
    host_write(2'd2, 16'd1);
    push(2'd3, 16'd100);
    push(2'd1, 16'h0000); push(2'd0, 16'h0002);
    push(2'd0, 16'h0000);
    base_done = done_cnt;
    host_write(2'd0, 16'h0001);
    wait_idle(2000);
    repeat (2) @(negedge clk);
    check("w_queue_empty", exp_q.size(), 32'd0);
    check("w_no_done", done_cnt - base_done, 32'd0);
    host_read(2'd0, rd);
    check("w_status_timeout", {16'd0, rd}, 32'h000E);
    trig_en = 1'b1;
`endif

    // reset pulse while in WAIT_TRIG
    trig_en = 1'b0;
    host_write(2'd2, 16'd1);
    push(2'd3, 16'd100);
    push(2'd1, 16'h0000); push(2'd0, 16'h0002);
    base_arm = arm_cnt;
    host_write(2'd0, 16'h0001);
    n = 0;
    while (!(arm_cnt == base_arm + 1 && avm_read) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("e_reach_wait_trig", {31'd0, (n < 200)}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("e_busy", {31'd0, busy}, 32'd0);
    check("e_done", {31'd0, done}, 32'd0);
    check("e_irq", {31'd0, irq}, 32'd0);
    check("e_avm", {avm_write, avm_read, avm_address, avm_writedata}, 32'd0);
    check("e_queue_empty", exp_q.size(), 32'd0);
    host_read(2'd0, rd);
    check("e_status", {16'd0, rd}, 32'd0);
    host_read(2'd1, rd);
    check("e_scan_reg", {16'd0, rd}, 32'd0);
    host_read(2'd2, rd);
    check("e_count_reg", {16'd0, rd}, 32'd0);
    host_read(2'd3, rd);
    check("e_last_size", {16'd0, rd}, 32'd0);

    // restart after reset begins from CFG_LEN
    trig_en = 1'b1;
    host_write(2'd2, 16'd1);
    host_write(2'd3, 16'd7);
    push(2'd3, 16'd7);
    push(2'd1, 16'h0000); push(2'd0, 16'h0002);
    base_done = done_cnt;
    host_write(2'd0, 16'h0001);
    wait_idle(2000);
    repeat (2) @(negedge clk);
    check("e_restart_queue", exp_q.size(), 32'd0);
    check("e_restart_done", done_cnt - base_done, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
